// File: rtl/cond_flag_pkg.sv
// Shared types and constants for the NZCV condition-flag unit.
// Branch kinds, LEGv8 condition codes and flag bit positions.
package cond_flag_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_UNCOND = 3'd1,
        BR_COND   = 3'd2,
        BR_CBZ    = 3'd3,
        BR_CBNZ   = 3'd4
    } br_type_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational LEGv8 condition-code evaluator: (cond, nzcv) -> pass.
module cond_eval
    import cond_flag_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_HS: pass = c;
            COND_LO: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !(c & !z);
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = !(!z & (n == v));
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register and ID-stage branch resolver with registered taken/not-taken.
// COND_FLAG_BYPASS_EN: forward EX flags to B.cond; otherwise stall dependent B.cond one cycle.
module cond_flag_unit
    import cond_flag_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic [3:0] ex_nzcv,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [2:0] br_type,
    input  logic [3:0] br_cond,
    input  logic       br_reg_nonzero,
    output logic       br_stall,
    output logic       br_resolved,
    output logic       br_taken,
    output logic [3:0] flags_q
);

    logic       ex_flag_hit;
    logic [3:0] eff_flags;
    logic       cond_ok;
    logic       accept;
    logic       taken_next;

    assign ex_flag_hit = ex_valid & ex_set_flags & !flush;

`ifdef COND_FLAG_BYPASS_EN
    assign eff_flags = ex_flag_hit ? ex_nzcv : flags_q;
    assign br_stall  = 1'b0;
`else
    // Without forwarding, a B.cond behind a flag-setter waits for flags_q to catch up.
    assign eff_flags = flags_q;
    assign br_stall  = br_valid & (br_type == BR_COND) & ex_flag_hit;
`endif

    cond_eval u_cond_eval (
        .cond (br_cond),
        .nzcv (eff_flags),
        .pass (cond_ok)
    );

    assign accept = br_valid & (br_type != BR_NONE) & !stall & !flush & !br_stall;

    always_comb begin
        taken_next = 1'b0;
        case (br_type)
            BR_UNCOND: taken_next = 1'b1;
            BR_COND:   taken_next = cond_ok;
            BR_CBZ:    taken_next = !br_reg_nonzero;
            BR_CBNZ:   taken_next = br_reg_nonzero;
            default:   taken_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= RESET_FLAGS;
            br_resolved <= 1'b0;
            br_taken    <= 1'b0;
        end else begin
            if (ex_flag_hit && !stall)
                flags_q <= ex_nzcv;
            br_resolved <= accept;
            br_taken    <= accept & taken_next;
        end
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the zero-detect path: the 64-bit OR reduction produces a "nonzero" indication; this block holds the NZCV condition flags and resolves conditional branches from them.
- Registers NZCV when a flag-setting instruction (ADDS/SUBS/ANDS) in EX commits.
- Evaluates B, B.cond, CBZ and CBNZ for the ID-stage branch, with EX-to-ID flag bypass.
- Returns a registered taken/not-taken decision to the fetch redirect logic.

Parameters:
- RESET_FLAGS, 4'b0000, reset value of NZCV in order {N,Z,C,V}.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_set_flags  in  1  EX instruction writes flags.
- ex_nzcv  in  4  ALU flags {N,Z,C,V} from EX; Z is the inverted OR-reduction output.
- stall  in  1  pipeline freeze; no state update and no branch acceptance.
- flush  in  1  squash EX and ID this cycle.
- br_valid  in  1  ID stage presents a branch.
- br_type  in  3  branch kind (br_type_e).
- br_cond  in  4  LEGv8 condition code for B.cond.
- br_reg_nonzero  in  1  OR-reduction of the CBZ/CBNZ operand Rt.
- br_stall  out  1  request to hold ID one cycle (see Optional Feature).
- br_resolved  out  1  one-cycle pulse: a decision is on br_taken.
- br_taken  out  1  branch taken; valid only while br_resolved=1.
- flags_q  out  4  architectural NZCV.

Behaviour:
- Reset: asynchronous, active-low.
  - flags_q=RESET_FLAGS, br_resolved=0, br_taken=0, br_stall=0.
  - A branch accepted in the cycle reset asserts produces no result.
- Flag write: at the edge, flags_q<=ex_nzcv when ex_valid & ex_set_flags & !stall & !flush. Otherwise flags_q holds.
- Effective flags for evaluation:
  - ex_nzcv if ex_valid & ex_set_flags & !flush (bypass).
  - Otherwise flags_q.
- Acceptance: a branch is accepted when br_valid & br_type!=BR_NONE & !stall & !flush & !br_stall.
- Latency: a branch accepted in cycle N gives br_resolved=1 in cycle N+1 with the decision on br_taken. In all other cycles br_resolved=0 and br_taken=0.
- Decision rules:
  - BR_UNCOND: taken.
  - BR_CBZ: taken iff !br_reg_nonzero.
  - BR_CBNZ: taken iff br_reg_nonzero.
  - BR_COND: taken iff cond_pass(br_cond, flags).
- cond_pass, using Z, N, C, V of the effective flags:
  - EQ 0000: Z. NE 0001: !Z.
  - HS 0010: C. LO 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !(C&!Z).
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: !(!Z&(N==V)).
  - AL 1110 and NV 1111: always taken.
- A stall in cycle N+1 does not extend the pulse. The consumer latches the decision.
- A flush in cycle N+1 does not cancel a result already registered.
- Simultaneous EX flag write and ID B.cond: the branch uses the new flags, per the bypass rules above.
- CBZ/CBNZ ignore flags entirely and never raise br_stall.

Optional Feature:
- Macro: COND_FLAG_BYPASS_EN.
- Defined: bypass as described above; br_stall is tied to 0.
- Undefined: no bypass; effective flags are always flags_q.
  - br_stall=1, combinationally, when br_valid & br_type==BR_COND & ex_valid & ex_set_flags & !flush.
  - The held B.cond is accepted the next cycle against the updated flags_q.
  - Cost: one bubble per dependent B.cond.

Decomposition:
- Package cond_flag_pkg contains:
  - br_type_e: BR_NONE=3'd0, BR_UNCOND=3'd1, BR_COND=3'd2, BR_CBZ=3'd3, BR_CBNZ=3'd4.
  - Condition-code localparams COND_EQ..COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_eval: purely combinational (cond[3:0], nzcv[3:0]) -> pass. Instantiated once.

Test Plan:
- Reset mid-operation: accept BR_UNCOND, assert reset_n=0 before the next edge -> br_resolved=0, flags_q=0000.
- SUBS writing ex_nzcv=0100, then B.EQ next cycle -> flags_q=0100, br_resolved=1, br_taken=1. Repeat with B.NE -> br_taken=0.
- Same-cycle SUBS ex_nzcv=1000 with B.LT in ID, flags_q=0000:
  - Bypass on: br_taken=1 at N+1.
  - Bypass off: br_stall=1 at N, then br_taken=1 at N+2.
- CBZ with br_reg_nonzero=0 -> taken; CBNZ with br_reg_nonzero=0 -> not taken. flags_q=1111 has no effect on either.
- flush=1 with ex_set_flags=1 (nzcv 0110) and br_valid=1 -> flags_q unchanged, no br_resolved at N+1.
- stall=1 for 3 cycles with B.GT presented -> no update, no pulse. Release with flags 0000 -> br_taken=1 exactly one cycle later.
